// File: rtl/mdu_pkg.sv
// mdu_pkg: shared opcodes, FSM states and datapath width for the HI/LO multiply/divide unit
package mdu_pkg;
   localparam int MDU_W = 32;
   localparam logic [3:0] MDU_NOP   = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MTHI  = 4'd5;
   localparam logic [3:0] MDU_MTLO  = 4'd6;
   localparam logic [3:0] MDU_MADD  = 4'd7;
   localparam logic [3:0] MDU_MADDU = 4'd8;
   localparam logic [3:0] MDU_MSUB  = 4'd9;
   localparam logic [3:0] MDU_MSUBU = 4'd10;
   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_SIGN} mdu_state_e;
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: iterative restoring divider on unsigned magnitudes, one quotient bit per cycle
module mdu_div_core
   import mdu_pkg::*;
#(
   parameter int DIV_ITER = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [MDU_W-1:0] dividend_i,
   input  logic [MDU_W-1:0] divisor_i,
   output logic             done_o,
   output logic [MDU_W-1:0] quo_o,
   output logic [MDU_W-1:0] rem_o
);
   logic             run_q;
   logic [5:0]       cnt_q;
   logic [MDU_W-1:0] rem_q, quo_q, div_q;
   logic [MDU_W:0]   shf, dif;
   assign shf    = {rem_q, quo_q[MDU_W-1]};
   assign dif    = shf - {1'b0, div_q};
   assign done_o = run_q && cnt_q == 6'(DIV_ITER - 1);
   assign quo_o  = quo_q;
   assign rem_o  = rem_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         div_q <= '0;
      end else if (abort_i) begin
         run_q <= 1'b0;
      end else if (start_i) begin
         run_q <= 1'b1;
         cnt_q <= '0;
         rem_q <= '0;
         quo_q <= dividend_i;
         div_q <= divisor_i;
      end else if (run_q) begin
         rem_q <= dif[MDU_W] ? shf[MDU_W-1:0] : dif[MDU_W-1:0];
         quo_q <= {quo_q[MDU_W-2:0], ~dif[MDU_W]};
         cnt_q <= cnt_q + 6'd1;
         run_q <= !done_o;
      end
   end
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit owning HI/LO; define MDU_MADD_EN for MADD/MADDU/MSUB/MSUBU
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int MUL_LAT  = 2,
   parameter int DIV_ITER = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [MDU_W-1:0] rs_data,
   input  logic [MDU_W-1:0] rt_data,
   input  logic             flush,
   input  logic             rhl_sel,
   output logic             busy,
   output logic [MDU_W-1:0] RHLOut,
   output logic [MDU_W-1:0] hi,
   output logic [MDU_W-1:0] lo
);
   mdu_state_e         state_q;
   logic [2:0]         cnt_q;
   logic [MDU_W:0]     ma_q, mb_q;
   logic               q_neg_q, r_neg_q;
   logic [MDU_W-1:0]   hi_q, lo_q, abs_rs, abs_rt, quo, rem;
   logic [2*MDU_W-1:0] prod, mul_res;
   logic               go, op_mul, op_acc, op_div, op_sgn, div_done;
   assign go     = start && !flush && state_q == ST_IDLE;
   assign op_mul = op == MDU_MULT || op == MDU_MULTU;
   assign op_div = op == MDU_DIV || op == MDU_DIVU;
   assign op_sgn = op == MDU_MULT || op == MDU_DIV || op == MDU_MADD || op == MDU_MSUB;
   assign abs_rs = (op_sgn && rs_data[MDU_W-1]) ? -rs_data : rs_data;
   assign abs_rt = (op_sgn && rt_data[MDU_W-1]) ? -rt_data : rt_data;
   assign prod   = 64'($signed(ma_q)) * 64'($signed(mb_q));
   assign busy   = state_q != ST_IDLE;
   assign hi     = hi_q;
   assign lo     = lo_q;
   assign RHLOut = rhl_sel ? hi_q : lo_q;
`ifdef MDU_MADD_EN
   logic acc_q, sub_q;
   assign op_acc  = op == MDU_MADD || op == MDU_MADDU || op == MDU_MSUB || op == MDU_MSUBU;
   assign mul_res = !acc_q ? prod : sub_q ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod;
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= 1'b0;
         sub_q <= 1'b0;
      end else if (go) begin
         acc_q <= op_acc;
         sub_q <= op == MDU_MSUB || op == MDU_MSUBU;
      end
   end
`else
   assign op_acc  = 1'b0;
   assign mul_res = prod;
`endif
   mdu_div_core #(.DIV_ITER(DIV_ITER)) u_div (
      .clk(clk), .rst(rst), .start_i(go && op_div), .abort_i(flush),
      .dividend_i(abs_rs), .divisor_i(abs_rt),
      .done_o(div_done), .quo_o(quo), .rem_o(rem)
   );
   // flush sits above the FSM so an in-flight result can never reach HI/LO
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else if (flush) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (start) begin
               if (op_mul || op_acc) begin
                  state_q <= ST_MUL;
                  cnt_q   <= op_acc ? 3'(MUL_LAT) : 3'(MUL_LAT - 1);
                  ma_q    <= {op_sgn & rs_data[MDU_W-1], rs_data};
                  mb_q    <= {op_sgn & rt_data[MDU_W-1], rt_data};
               end else if (op_div) begin
                  state_q <= ST_DIV;
                  q_neg_q <= op_sgn & (rs_data[MDU_W-1] ^ rt_data[MDU_W-1]);
                  r_neg_q <= op_sgn & rs_data[MDU_W-1];
               end else if (op == MDU_MTHI) begin
                  hi_q <= rs_data;
               end else if (op == MDU_MTLO) begin
                  lo_q <= rs_data;
               end
            end
            ST_MUL: if (cnt_q == 3'd0) begin
               {hi_q, lo_q} <= mul_res;
               state_q      <= ST_IDLE;
            end else begin
               cnt_q <= cnt_q - 3'd1;
            end
            ST_DIV: if (div_done) state_q <= ST_SIGN;
            ST_SIGN: begin
               lo_q    <= q_neg_q ? -quo : quo;
               hi_q    <= r_neg_q ? -rem : rem;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: vector table, corner sequences and random ops against an arithmetic HI/LO model
module tb_mdu_hilo;
   import mdu_pkg::*;
   localparam int ML = 2;
   localparam int DL = 33;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0, rhl_sel = 1'b0;
   logic [3:0]  op = MDU_NOP;
   logic [31:0] rs_data = '0, rt_data = '0;
   logic        busy;
   logic [31:0] RHLOut, hi, lo;
   int          checks = 0, errors = 0;

   mdu_hilo #(.MUL_LAT(ML), .DIV_ITER(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
      .flush(flush), .rhl_sel(rhl_sel), .busy(busy), .RHLOut(RHLOut), .hi(hi), .lo(lo)
   );
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b, hi, lo;
      int          cyc;
   } vec_t;
   vec_t vq[$];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; rs_data = a; rt_data = b; start = 1'b1;
      tick();
      start = 1'b0; op = MDU_NOP;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic chk_out(input string nm, input logic [31:0] eh, input logic [31:0] el);
      chk({nm, " hi"}, 64'(hi), 64'(eh));
      chk({nm, " lo"}, 64'(lo), 64'(el));
      rhl_sel = 1'b0; #1;
      chk({nm, " rhl0"}, 64'(RHLOut), 64'(el));
      rhl_sel = 1'b1; #1;
      chk({nm, " rhl1"}, 64'(RHLOut), 64'(eh));
      rhl_sel = 1'b0;
   endtask

   function automatic logic [63:0] ref_op(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
      longint      sa = longint'($signed(a)), sb = longint'($signed(b)), q, r;
      logic [63:0] ua = {32'b0, a}, ub = {32'b0, b};
      case (o)
         MDU_MULT:  return sa * sb;
         MDU_MULTU: return ua * ub;
         MDU_DIVU:  return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
         MDU_DIV: begin
            if (b == 0) return {a, (sa < 0) ? 32'h1 : 32'hFFFFFFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         MDU_MTHI:  return {a, acc[31:0]};
         MDU_MTLO:  return {acc[63:32], a};
`ifdef MDU_MADD_EN
         MDU_MADD:  return acc + sa * sb;
         MDU_MADDU: return acc + ua * ub;
         MDU_MSUB:  return acc - sa * sb;
         MDU_MSUBU: return acc - ua * ub;
`endif
         default:   return acc;
      endcase
   endfunction

   function automatic int ref_lat(input logic [3:0] o);
      if (o == MDU_MULT || o == MDU_MULTU) return ML;
      if (o == MDU_DIV || o == MDU_DIVU) return DL;
`ifdef MDU_MADD_EN
      if (o >= MDU_MADD && o <= MDU_MSUBU) return ML + 1;
`endif
      return 0;
   endfunction

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(7))
         0: return 32'h0;
         1: return 32'($urandom_range(9));
         2: return 32'h80000000;
         3: return 32'hFFFFFFFF;
         4: return -32'($urandom_range(9));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          n;
      logic [63:0] mdl;
      logic [3:0]  ops[11] = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO,
                                MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU, MDU_NOP};
      vq.push_back('{MDU_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, ML});
      vq.push_back('{MDU_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, ML});
      vq.push_back('{MDU_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DL});
      vq.push_back('{MDU_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, DL});
      vq.push_back('{MDU_DIVU,  32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, DL});
      vq.push_back('{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, DL});
      vq.push_back('{MDU_MTHI,  32'd0, 32'd0, 32'd0, 32'h80000000, 0});
      vq.push_back('{MDU_MTLO,  32'd5, 32'd0, 32'd0, 32'd5, 0});
`ifdef MDU_MADD_EN
      vq.push_back('{MDU_MADD,  32'd3, 32'd4, 32'd0, 32'd17, ML + 1});
      vq.push_back('{MDU_MTLO,  32'd5, 32'd0, 32'd0, 32'd5, 0});
      vq.push_back('{MDU_MSUBU, 32'd1, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, ML + 1});
`else
      vq.push_back('{MDU_MADD,  32'd3, 32'd4, 32'd0, 32'd5, 0});
      vq.push_back('{MDU_MSUBU, 32'd1, 32'd6, 32'd0, 32'd5, 0});
`endif

      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("reset busy", 64'(busy), 64'(0));
      chk_out("reset", 32'd0, 32'd0);

      foreach (vq[i]) begin
         issue(vq[i].op, vq[i].a, vq[i].b);
         wait_idle(n);
         chk($sformatf("vec%0d cycles", i), 64'(n), 64'(vq[i].cyc));
         chk_out($sformatf("vec%0d", i), vq[i].hi, vq[i].lo);
      end

      issue(MDU_DIVU, 32'd100, 32'd7);
      repeat (3) tick();
      issue(MDU_MTHI, 32'h55, 32'd0);
      issue(MDU_MULT, 32'd9, 32'd9);
      wait_idle(n);
      chk("busy-start cycles", 64'(n), 64'(DL - 5));
      chk_out("busy-start", 32'd2, 32'd14);

      issue(MDU_MTHI, 32'h11, 32'd0);
      issue(MDU_MTLO, 32'h22, 32'd0);
      issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
      repeat (8) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush busy", 64'(busy), 64'(0));
      chk_out("flush", 32'h11, 32'h22);
      repeat (40) tick();
      chk_out("flush late", 32'h11, 32'h22);
      op = MDU_MULT; rs_data = 32'd3; rt_data = 32'd3; start = 1'b1; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0; op = MDU_NOP;
      chk("flush+start busy", 64'(busy), 64'(0));
      repeat (4) tick();
      chk_out("flush+start", 32'h11, 32'h22);
      issue(MDU_DIVU, 32'd100, 32'd7);
      wait_idle(n);
      chk("div after flush cycles", 64'(n), 64'(DL));
      chk_out("div after flush", 32'd2, 32'd14);

      issue(MDU_MULT, 32'd5, 32'd6);
      chk("mid-mult busy", 64'(busy), 64'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst-mid busy", 64'(busy), 64'(0));
      chk_out("rst-mid", 32'd0, 32'd0);
      repeat (4) tick();
      chk_out("rst-mid late", 32'd0, 32'd0);

      mdl = 64'd0;
      for (int k = 0; k < 40; k++) begin
         logic [3:0]  o;
         logic [31:0] a, b;
         o = ops[$urandom_range(10)];
         a = rnd_opnd();
         b = rnd_opnd();
         mdl = ref_op(o, a, b, mdl);
         issue(o, a, b);
         wait_idle(n);
         chk($sformatf("rnd%0d op%0d cycles", k, o), 64'(n), 64'(ref_lat(o)));
         chk($sformatf("rnd%0d op%0d %h/%h hilo", k, o, a, b), {hi, lo}, mdl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with the architectural HI/LO registers.
- Sits in EX, beside ALU1. It consumes forwarded operands from the rs/rt forwarding muxes and produces RHLOut, which the EX result-select mux routes as the MFHI/MFLO result.
- Asserts busy so the hazard unit stalls any HI/LO reader or new MDU op until the result commits.

Parameters:
- MUL_LAT, 2: cycles from accepted MULT/MULTU until HI/LO update. Range 1..4.
- DIV_ITER, 32: restoring-division iterations, one per cycle. Fixed 32 for a 32-bit datapath; parameterised for test shortening only.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  launch op (one-cycle pulse from EX)
- op  in  4  MDU opcode (package constants)
- rs_data  in  32  forwarded rs operand
- rt_data  in  32  forwarded rt operand
- flush  in  1  exception/eret flush of EX
- rhl_sel  in  1  0=read LO, 1=read HI
- busy  out  1  op in flight
- RHLOut  out  32  selected HI or LO
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: hi=0, lo=0, busy=0, state=IDLE, counter=0. RHLOut follows hi/lo combinationally, so RHLOut=0 after reset.
- Ops:
  - MULT/MULTU: {hi,lo} = rs*rt, signed/unsigned, 64-bit result.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - MTHI/MTLO: write rs_data to hi/lo on the next edge, single cycle, no busy.
  - NOP: ignored.
- FSM states: IDLE, MUL, DIV, SIGN (DIV only).
  - IDLE + start + MULT/U -> MUL. Operands are latched and the counter is loaded with MUL_LAT-1. busy=1 from the next cycle. When counter==0: hi/lo are written on that edge, busy drops, state returns to IDLE. Total = MUL_LAT cycles from start to hi/lo valid.
  - IDLE + start + DIV/U -> DIV. Operand magnitudes are latched (signed op: abs values, and the quotient/remainder sign flags are recorded). One restoring step is done per cycle for DIV_ITER cycles, then SIGN, where the quotient is negated if the signs differ and the remainder takes the dividend's sign. hi/lo are written at the end of SIGN, then IDLE. Latency = DIV_ITER+1 cycles (33).
- busy = (state != IDLE). hi/lo are visible the cycle after busy falls.
- start while busy is ignored; the hazard unit guarantees it never occurs. The bench checks it is dropped with no state corruption.
- start and MTHI/MTLO in the same cycle as completion is impossible, because busy=1 blocks it.
- Divide by zero: deterministic, not a trap. Restoring algorithm on magnitudes gives quotient magnitude 0xFFFFFFFF and remainder = |dividend|, then SIGN rules are applied. DIVU 7/0 gives lo=0xFFFFFFFF, hi=7.
- 0x80000000 / -1 (DIV): lo=0x80000000, hi=0 (wraps).
- flush: any state -> IDLE next edge, busy=0, hi/lo unchanged, in-flight result discarded. flush with start in the same cycle: flush wins, nothing launched.
- rst mid-operation: identical to the reset values above, with no partial write.
- Arithmetic: 33-bit partial remainder. Subtraction is unsigned on magnitudes. Multiplier operands are sign/zero-extended to 33 bits, and the product is truncated to 64.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined: adds opcodes MADD/MADDU/MSUB/MSUBU. {hi,lo} = {hi,lo} ± rs*rt, committed after MUL_LAT+1 cycles; the extra cycle is the 64-bit add.
- When undefined: these opcodes decode as NOP (no busy, no write), and the accumulate adder is absent.

Decomposition:
- Shared package mdu_pkg:
  - op encodings: MDU_NOP, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU
  - FSM state encodings
  - width constant MDU_W=32
- One sub-module, mdu_div_core: the iterative restoring divider. It has a start/done handshake, unsigned magnitudes in, and quotient/remainder out. The top handles signs, multiplier, HI/LO and flush.

Test Plan:
- Reset then read: rst=1 for 2 cycles -> hi=lo=0, busy=0, RHLOut=0 for both rhl_sel values.
- MULT rs=0xFFFFFFFE (-2), rt=3 -> busy for MUL_LAT cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> busy for 33 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- DIVU 7/0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Pre-load MTHI 0x11, MTLO 0x22, start DIV, assert flush on cycle 10 -> busy=0 on the next cycle, hi=0x11, lo=0x22. Assert rst mid-MULT -> hi=lo=0.
- With MDU_MADD_EN: hi=0, lo=5, MADD 3*4 -> lo=17 after MUL_LAT+1 cycles. MSUBU 1*6 on {0,5} -> {0xFFFFFFFF,0xFFFFFFFF}. Without the macro: MADD leaves hi/lo unchanged and busy stays 0.
